// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants, counter helpers and BTB entry type
package bp_pkg;

  // Entry fields are sized for the widest supported configuration; high bits stay zero.
  localparam int BP_MAX_XLEN  = 64;
  localparam int BP_MAX_CNT_W = 4;

  typedef struct packed {
    logic                    valid;
    logic [BP_MAX_XLEN-1:0]  tag;
    logic [BP_MAX_XLEN-1:0]  target;
    logic [BP_MAX_CNT_W-1:0] cnt;
  } bp_entry_t;

  function automatic logic [BP_MAX_CNT_W-1:0] cnt_init(input int cnt_w);
    return BP_MAX_CNT_W'((1 << (cnt_w - 1)) - 1);
  endfunction

  function automatic logic [BP_MAX_CNT_W-1:0] cnt_weak_taken(input int cnt_w);
    return BP_MAX_CNT_W'(1 << (cnt_w - 1));
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, decode update and D-record signals
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            stall_F;
  logic            flush_D;
  logic [XLEN-1:0] PC_F;
  logic            pred_jump_F;
  logic [XLEN-1:0] pred_target_F;
  logic            upd_valid_D;
  logic [XLEN-1:0] upd_PC_D;
  logic            upd_taken_D;
  logic [XLEN-1:0] upd_target_D;
  logic            pred_jump_D;
  logic [XLEN-1:0] pred_target_D;
  logic            mispredict_D;

  modport master (
    output stall_F, flush_D, PC_F, upd_valid_D, upd_PC_D, upd_taken_D, upd_target_D,
    input  pred_jump_F, pred_target_F, pred_jump_D, pred_target_D, mispredict_D
  );

  modport slave (
    input  stall_F, flush_D, PC_F, upd_valid_D, upd_PC_D, upd_taken_D, upd_target_D,
    output pred_jump_F, pred_target_F, pred_jump_D, pred_target_D, mispredict_D
  );
endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational saturating up/down counter step
module bp_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_W'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating-counter direction prediction
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int XLEN    = 32
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  bp_entry_t       tbl_q [ENTRIES];
  bp_entry_t       tbl_d [ENTRIES];
  logic            pred_jump_D_q, pred_jump_D_d;
  logic [XLEN-1:0] pred_target_D_q, pred_target_D_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             pred_jump_F;
  logic [XLEN-1:0]  pred_target_F;
  logic [CNT_W-1:0] u_cnt_next;
  logic             unused_pc_bits;

  assign f_idx = bp.PC_F[IDX_W+1:2];
  assign f_tag = bp.PC_F[XLEN-1:IDX_W+2];
  assign u_idx = bp.upd_PC_D[IDX_W+1:2];
  assign u_tag = bp.upd_PC_D[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{bp.PC_F[1:0], bp.upd_PC_D[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign f_hit         = tbl_q[f_idx].valid && (tbl_q[f_idx].tag == BP_MAX_XLEN'(f_tag));
  assign pred_jump_F   = f_hit && tbl_q[f_idx].cnt[CNT_W-1];
  assign pred_target_F = pred_jump_F ? tbl_q[f_idx].target[XLEN-1:0] : '0;

  assign u_hit = tbl_q[u_idx].valid && (tbl_q[u_idx].tag == BP_MAX_XLEN'(u_tag));

  bp_sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .cnt_i (tbl_q[u_idx].cnt[CNT_W-1:0]),
    .inc_i (bp.upd_taken_D),
    .cnt_o (u_cnt_next)
  );

  always_comb begin
    tbl_d = tbl_q;
    if (bp.upd_valid_D) begin
      if (u_hit) begin
        tbl_d[u_idx].cnt = BP_MAX_CNT_W'(u_cnt_next);
        if (bp.upd_taken_D) tbl_d[u_idx].target = BP_MAX_XLEN'(bp.upd_target_D);
      end else if (bp.upd_taken_D) begin
        tbl_d[u_idx].valid  = 1'b1;
        tbl_d[u_idx].tag    = BP_MAX_XLEN'(u_tag);
        tbl_d[u_idx].target = BP_MAX_XLEN'(bp.upd_target_D);
        tbl_d[u_idx].cnt    = cnt_weak_taken(CNT_W);
      end
    end
  end

  always_comb begin
    pred_jump_D_d   = pred_jump_D_q;
    pred_target_D_d = pred_target_D_q;
    if (bp.flush_D) begin
      pred_jump_D_d   = 1'b0;
      pred_target_D_d = '0;
    end else if (!bp.stall_F) begin
      pred_jump_D_d   = pred_jump_F;
      pred_target_D_d = pred_target_F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: cnt_init(CNT_W)};
      end
      pred_jump_D_q   <= 1'b0;
      pred_target_D_q <= '0;
    end else begin
      tbl_q           <= tbl_d;
      pred_jump_D_q   <= pred_jump_D_d;
      pred_target_D_q <= pred_target_D_d;
    end
  end

  assign bp.pred_jump_F   = pred_jump_F;
  assign bp.pred_target_F = pred_target_F;
  assign bp.pred_jump_D   = pred_jump_D_q;
  assign bp.pred_target_D = pred_target_D_q;
  assign bp.mispredict_D  = bp.upd_valid_D &&
                            ((pred_jump_D_q != bp.upd_taken_D) ||
                             (bp.upd_taken_D && (pred_target_D_q != bp.upd_target_D)));
endmodule
